load_align_queue: RTL and testbench
===================================

Name: load_align_queue

Overview:
- Parametrised successor to the W-stage load-data selector.
- Tracks outstanding loads between the data-memory request and response.
- Checks alignment at issue, and holds per-load metadata (byte offset, size, sign mode, destination register) in an in-order queue.
- On response, extracts and extends the addressed sub-word and delivers a registered writeback result. Supports variable memory latency, multiple outstanding loads, 32/64-bit datapaths and pipeline flush.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64; byte lanes NB = DATA_W/8, OFF_W = log2(NB)
DEPTH, 4, max outstanding loads; power of two, >= 2
RD_W, 5, destination register tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  load request from M stage
req_ready  out  1  request accepted this cycle when high with req_valid
req_addr_lo  in  OFF_W  low address bits
req_size  in  2  0 byte, 1 half, 2 word, 3 dword (64-bit only)
req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
req_rd  in  RD_W  destination register tag
req_adel  out  1  combinational address-error-load flag for the current request
mem_req_valid  out  1  issue to data memory
mem_req_ready  in  1  memory can accept
mem_rsp_valid  in  1  memory read data valid (in order, one per issued request)
mem_rsp_data  in  DATA_W  raw aligned memory word
flush  in  1  discard all in-flight loads
out_valid  out  1  writeback result valid (one-cycle pulse per load)
out_data  out  DATA_W  extracted, extended result
out_rd  out  RD_W  destination tag of result
busy  out  1  queue non-empty or draining
err_spurious  out  1  sticky: response seen with nothing outstanding and nothing to discard

Behaviour:
- Reset (async, rst=1): queue pointers and count = 0, discard_cnt = 0, state = RUN. out_valid, out_data, out_rd, err_spurious = 0.
- Misalignment, combinational:
  - Half with addr_lo[0] != 0.
  - Word with addr_lo[1:0] != 0.
  - Dword with addr_lo[2:0] != 0.
  - size 3 when DATA_W = 32.
  - req_adel = req_valid & misaligned. A misaligned request is never issued or enqueued; mem_req_valid = 0 for it.
- Issue:
  - mem_req_valid = req_valid & ~misaligned & ~full & ~flush & (state == RUN).
  - req_ready = mem_req_ready & ~full & ~flush & (state == RUN).
  - Enqueue on mem_req_valid & mem_req_ready.
  - full is count == DEPTH. A same-cycle pop does not free a slot for a same-cycle push.
- Response (state RUN):
  - On mem_rsp_valid, pop the head and extract with k = stored offset.
  - Byte: lane k = data[8k+7:8k].
  - Half: data[8k+15:8k].
  - Word: data[8k+31:8k].
  - Dword: full data.
  - Extend to DATA_W with zeros if unsigned, else with the lane MSB. DATA_W=32 word and DATA_W=64 dword have nothing to extend.
  - Registered: out_valid = 1, out_data, out_rd appear the cycle after mem_rsp_valid (latency 1). out_valid is otherwise 0.
  - Push and pop in the same cycle: count unchanged.
- States:
  - RUN to DRAIN: on flush with (count minus same-cycle pop) > 0. discard_cnt is loaded with that value and the queue is cleared.
  - RUN on flush with nothing left: queue cleared, stay RUN.
  - DRAIN: each mem_rsp_valid decrements discard_cnt and produces no output. On reaching 0, go to RUN next cycle.
  - Flush during DRAIN: no effect.
- Flush always forces out_valid to 0 in the next cycle, including a result from a response arriving in the flush cycle.
- Response when count == 0 and state RUN: ignored, no output, err_spurious set (cleared only by reset).
- busy = (count != 0) | (state == DRAIN).
- Reset mid-operation: everything is abandoned immediately. Late responses after reset count as spurious.

Test Plan:
1. DATA_W=32. LB addr_lo=3, signed; rsp 0x80FF_1234 -> next cycle out_data=0xFFFF_FF80, out_valid pulse 1 cycle, out_rd matches. Then LBU same -> 0x0000_0080.
2. LH addr_lo=2, signed, rsp 0x8001_7FFF -> 0xFFFF_8001. LH addr_lo=1 -> req_adel=1, mem_req_valid=0, count unchanged. LW addr_lo=2 -> req_adel=1.
3. DEPTH=4. Issue 4 loads (rd 1..4) with no responses -> req_ready=0 at count 4. Return 4 responses back-to-back -> 4 consecutive out_valid pulses, rd 1,2,3,4 in order.
4. 3 outstanding, flush in a cycle with no response -> DRAIN with discard_cnt=3, req_ready=0. 3 responses produce no output, then RUN. Next load returns normally.
5. Flush coinciding with mem_rsp_valid and 2 outstanding -> discard_cnt=1, no out_valid for either load.
6. DATA_W=64. LW addr_lo=4, signed; rsp 0x8000_0000_0000_0001 -> 0xFFFF_FFFF_8000_0000. LD addr_lo=0 returns raw data. mem_rsp_valid with queue empty -> err_spurious=1 stays high until rst.

Source files
------------

// File: rtl/load_align_queue.sv
// load_align_queue: in-order outstanding-load tracker with alignment check, sub-word extraction and flush drain
module load_align_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int RD_W   = 5,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OFF_W-1:0]  req_addr_lo,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [RD_W-1:0]   req_rd,
  output logic              req_adel,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              busy,
  output logic              err_spurious
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t r_state, w_state_nx;

  logic [OFF_W-1:0]      r_q_off  [DEPTH];
  logic [1:0]            r_q_size [DEPTH];
  logic                  r_q_uns  [DEPTH];
  logic [RD_W-1:0]       r_q_rd   [DEPTH];
  logic [PTR_W-1:0]      r_wp, r_rp;
  logic [CNT_W-1:0]      r_cnt, r_disc;
  logic                  r_out_valid, r_err;
  logic [DATA_W-1:0]     r_out_data;
  logic [RD_W-1:0]       r_out_rd;

  logic [2:0]            w_a3;
  logic                  w_mis, w_run, w_full, w_issue_ok;
  logic                  w_push, w_pop, w_spur, w_flush_run;
  logic [CNT_W-1:0]      w_left;
  logic [OFF_W-1:0]      w_off;
  logic [1:0]            w_size;
  logic                  w_uns;
  logic [RD_W-1:0]       w_rd;
  logic [DATA_W-1:0]     w_sh, w_ext;

  // Offsets narrower than 3 bits are zero-extended so one alignment rule covers both widths.
  assign w_a3  = 3'(req_addr_lo);
  assign w_mis = (req_size == 2'd1 & w_a3[0])
               | (req_size == 2'd2 & |w_a3[1:0])
               | (req_size == 2'd3 & ((DATA_W == 32) | |w_a3));

  assign w_run       = (r_state == RUN);
  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_issue_ok  = ~w_full & ~flush & w_run;
  assign req_adel    = req_valid & w_mis;
  assign mem_req_valid = req_valid & ~w_mis & w_issue_ok;
  assign req_ready   = mem_req_ready & w_issue_ok;
  assign w_push      = mem_req_valid & mem_req_ready;
  assign w_pop       = mem_rsp_valid & w_run & (r_cnt != '0);
  assign w_spur      = mem_rsp_valid & w_run & (r_cnt == '0);
  assign w_flush_run = flush & w_run;
  assign w_left      = r_cnt - CNT_W'(w_pop);

  assign w_off  = r_q_off[r_rp];
  assign w_size = r_q_size[r_rp];
  assign w_uns  = r_q_uns[r_rp];
  assign w_rd   = r_q_rd[r_rp];

  // Addressed lane moved to bit 0, then widened per size and sign mode.
  assign w_sh  = mem_rsp_data >> {w_off, 3'b000};
  assign w_ext = (w_size == 2'd0) ? (w_uns ? DATA_W'(w_sh[7:0])  : DATA_W'($signed(w_sh[7:0])))  :
                 (w_size == 2'd1) ? (w_uns ? DATA_W'(w_sh[15:0]) : DATA_W'($signed(w_sh[15:0]))) :
                 (w_size == 2'd2) ? (w_uns ? DATA_W'(w_sh[31:0]) : DATA_W'($signed(w_sh[31:0]))) :
                 w_sh;

  assign busy         = (r_cnt != '0) | ~w_run;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_rd       = r_out_rd;
  assign err_spurious = r_err;

  // Metadata slots written at the tail; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_off[r_wp]  <= req_addr_lo;
      r_q_size[r_wp] <= req_size;
      r_q_uns[r_wp]  <= req_unsigned;
      r_q_rd[r_wp]   <= req_rd;
    end
  end

  // Queue pointers and occupancy; a flush in RUN empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_flush_run) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PTR_W'(w_push);
      r_rp  <= r_rp + PTR_W'(w_pop);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nx;
  end

  // Enter DRAIN when a flush leaves loads in flight; leave on the last discarded response.
  always_comb begin
    w_state_nx = w_run ? ((w_flush_run & |w_left) ? DRAIN : RUN)
                       : ((mem_rsp_valid & (r_disc == CNT_W'(1))) ? RUN : DRAIN);
  end

  // Number of responses still owed to flushed loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_disc <= '0;
    else if (w_flush_run)             r_disc <= w_left;
    else if (~w_run & mem_rsp_valid)  r_disc <= r_disc - CNT_W'(1);
  end

  // Registered writeback; a flush suppresses the result of its own cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
    end else begin
      r_out_valid <= w_pop & ~flush;
      if (w_pop) begin
        r_out_data <= w_ext;
        r_out_rd   <= w_rd;
      end
    end
  end

  // Sticky flag for a response with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_err <= 1'b0;
    else if (w_spur) r_err <= 1'b1;
  end
endmodule

// File: tb/tb_load_align_queue.sv
// tb_load_align_queue: directed and random checks of 32- and 64-bit load queues against a queue model
module tb_load_align_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rv[2], ru[2], mrdy[2], rspv[2], fl[2];
  logic [2:0]  ra[2];
  logic [1:0]  rs[2];
  logic [4:0]  rr[2];
  logic [63:0] rspd[2];
  logic        o_rdy[2], o_adel[2], o_mrv[2], o_ov[2], o_busy[2], o_err[2];
  logic [4:0]  o_rd[2];
  logic [31:0] od_a;
  logic [63:0] od_b;

  load_align_queue #(.DATA_W(32)) u_a (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(o_rdy[0]), .req_addr_lo(ra[0][1:0]),
    .req_size(rs[0]), .req_unsigned(ru[0]), .req_rd(rr[0]), .req_adel(o_adel[0]),
    .mem_req_valid(o_mrv[0]), .mem_req_ready(mrdy[0]), .mem_rsp_valid(rspv[0]),
    .mem_rsp_data(rspd[0][31:0]), .flush(fl[0]), .out_valid(o_ov[0]), .out_data(od_a),
    .out_rd(o_rd[0]), .busy(o_busy[0]), .err_spurious(o_err[0]));

  load_align_queue #(.DATA_W(64)) u_b (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(o_rdy[1]), .req_addr_lo(ra[1]),
    .req_size(rs[1]), .req_unsigned(ru[1]), .req_rd(rr[1]), .req_adel(o_adel[1]),
    .mem_req_valid(o_mrv[1]), .mem_req_ready(mrdy[1]), .mem_rsp_valid(rspv[1]),
    .mem_rsp_data(rspd[1]), .flush(fl[1]), .out_valid(o_ov[1]), .out_data(od_b),
    .out_rd(o_rd[1]), .busy(o_busy[1]), .err_spurious(o_err[1]));

  typedef struct packed {
    logic [2:0] off;
    logic [1:0] sz;
    logic       uns;
    logic [4:0] rd;
  } ent_t;

  ent_t        mq[2][$];
  int          mdisc[2];
  bit          mov[2], merr[2];
  logic [63:0] mod[2];
  logic [4:0]  mrd[2];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] d, input ent_t e, input int w);
    logic [63:0] v;
    logic signed [63:0] s;
    int n;
    n = 8 << e.sz;
    v = (w == 32) ? (d & 64'hFFFF_FFFF) : d;
    v = v >> (8 * e.off);
    if (n < 64) begin
      v = v << (64 - n);
      if (e.uns) v = v >> (64 - n);
      else begin
        s = v;
        s = s >>> (64 - n);
        v = s;
      end
    end
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic idle();
    for (int u = 0; u < 2; u++) begin
      rv[u] = 0; ra[u] = 0; rs[u] = 0; ru[u] = 0; rr[u] = 0;
      mrdy[u] = 1; rspv[u] = 0; rspd[u] = 0; fl[u] = 0;
    end
  endtask

  task automatic req(input int u, input logic [2:0] a, input logic [1:0] s, input logic un, input logic [4:0] rd);
    rv[u] = 1; ra[u] = a; rs[u] = s; ru[u] = un; rr[u] = rd;
  endtask

  task automatic rsp(input int u, input logic [63:0] d);
    rspv[u] = 1; rspd[u] = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #1;
    for (int u = 0; u < 2; u++) begin
      mq[u].delete(); mdisc[u] = 0; mov[u] = 0; merr[u] = 0;
      chk($sformatf("rst_ov_%0d", u), o_ov[u], 0);
      chk($sformatf("rst_rd_%0d", u), o_rd[u], 0);
      chk($sformatf("rst_err_%0d", u), o_err[u], 0);
      chk($sformatf("rst_busy_%0d", u), o_busy[u], 0);
      chk($sformatf("rst_data_%0d", u), u ? od_b : {32'b0, od_a}, 0);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic cyc();
    logic [2:0] a;
    bit mis, run, full, emrv, pop;
    int w;
    ent_t e;
    #1;
    for (int u = 0; u < 2; u++) begin
      w = u ? 64 : 32;
      a = u ? ra[u] : (ra[u] & 3'd3);
      mis = (rs[u] == 2'd1 && a[0]) || (rs[u] == 2'd2 && a[1:0] != 0) ||
            (rs[u] == 2'd3 && (w == 32 || a != 0));
      run = (mdisc[u] == 0);
      full = (mq[u].size() == 4);
      emrv = rv[u] && !mis && !full && !fl[u] && run;
      chk($sformatf("adel_%0d", u), o_adel[u], rv[u] && mis);
      chk($sformatf("mreqv_%0d", u), o_mrv[u], emrv);
      chk($sformatf("ready_%0d", u), o_rdy[u], mrdy[u] && !full && !fl[u] && run);
      chk($sformatf("busy_%0d", u), o_busy[u], mq[u].size() != 0 || !run);
      pop = rspv[u] && run && mq[u].size() > 0;
      if (rspv[u] && run && mq[u].size() == 0) merr[u] = 1;
      if (!run && rspv[u]) mdisc[u]--;
      mov[u] = pop && !fl[u];
      if (pop) begin
        mod[u] = ext(rspd[u], mq[u][0], w);
        mrd[u] = mq[u][0].rd;
        void'(mq[u].pop_front());
      end
      if (emrv && mrdy[u]) begin
        e.off = a; e.sz = rs[u]; e.uns = ru[u]; e.rd = rr[u];
        mq[u].push_back(e);
      end
      if (fl[u] && run) begin
        mdisc[u] = mq[u].size();
        mq[u].delete();
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("outv_%0d", u), o_ov[u], mov[u]);
      if (mov[u]) begin
        chk($sformatf("outd_%0d", u), u ? od_b : {32'b0, od_a}, mod[u]);
        chk($sformatf("outrd_%0d", u), o_rd[u], mrd[u]);
      end
      chk($sformatf("err_%0d", u), o_err[u], merr[u]);
    end
  endtask

  initial begin
    idle();
    #2;
    do_reset();
    // byte loads, signed then unsigned
    idle(); req(0, 3'd3, 2'd0, 1'b0, 5'd7); cyc();
    idle(); rsp(0, 64'h80FF_1234); cyc();
    chk("t1_lb", {32'b0, od_a}, 64'hFFFF_FF80);
    chk("t1_rd", o_rd[0], 5'd7);
    idle(); cyc();
    idle(); req(0, 3'd3, 2'd0, 1'b1, 5'd8); cyc();
    idle(); rsp(0, 64'h80FF_1234); cyc();
    chk("t1_lbu", {32'b0, od_a}, 64'h0000_0080);
    // halfword and misaligned requests
    idle(); req(0, 3'd2, 2'd1, 1'b0, 5'd9); cyc();
    idle(); rsp(0, 64'h8001_7FFF); cyc();
    chk("t2_lh", {32'b0, od_a}, 64'hFFFF_8001);
    idle(); req(0, 3'd1, 2'd1, 1'b0, 5'd3); #1;
    chk("t2_lh_adel", o_adel[0], 1);
    chk("t2_lh_noiss", o_mrv[0], 0);
    cyc();
    idle(); req(0, 3'd2, 2'd2, 1'b0, 5'd3); #1;
    chk("t2_lw_adel", o_adel[0], 1);
    cyc();
    chk("t2_idle", o_busy[0], 0);
    // fill the queue then drain in order
    for (int i = 1; i <= 4; i++) begin
      idle(); req(0, 3'd0, 2'd2, 1'b0, 5'(i)); cyc();
    end
    idle(); req(0, 3'd0, 2'd2, 1'b0, 5'd5); #1;
    chk("t3_full_rdy", o_rdy[0], 0);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      idle(); rsp(0, 64'(32'h1111_1111 * i)); cyc();
      chk($sformatf("t3_ord%0d", i), o_rd[0], 5'(i));
      chk($sformatf("t3_ov%0d", i), o_ov[0], 1);
    end
    idle(); cyc();
    // flush with three in flight
    for (int i = 1; i <= 3; i++) begin
      idle(); req(0, 3'd0, 2'd2, 1'b0, 5'(10 + i)); cyc();
    end
    idle(); fl[0] = 1; cyc();
    idle(); req(0, 3'd0, 2'd2, 1'b0, 5'd20); #1;
    chk("t4_drain_rdy", o_rdy[0], 0);
    chk("t4_drain_busy", o_busy[0], 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); rsp(0, 64'h1234_5678); cyc();
      chk($sformatf("t4_drop%0d", i), o_ov[0], 0);
    end
    chk("t4_run", o_busy[0], 0);
    idle(); req(0, 3'd0, 2'd2, 1'b0, 5'd21); cyc();
    idle(); rsp(0, 64'hCAFE_BABE); cyc();
    chk("t4_after", {32'b0, od_a}, 64'hCAFE_BABE);
    // flush coinciding with a response
    idle(); req(0, 3'd0, 2'd2, 1'b0, 5'd22); cyc();
    idle(); req(0, 3'd0, 2'd2, 1'b0, 5'd23); cyc();
    idle(); rsp(0, 64'h1); fl[0] = 1; cyc();
    chk("t5_nov0", o_ov[0], 0);
    idle(); rsp(0, 64'h2); cyc();
    chk("t5_nov1", o_ov[0], 0);
    chk("t5_run", o_busy[0], 0);
    // 64-bit word and dword
    idle(); req(1, 3'd4, 2'd2, 1'b0, 5'd5); cyc();
    idle(); rsp(1, 64'h8000_0000_0000_0001); cyc();
    chk("t6_lw", od_b, 64'hFFFF_FFFF_8000_0000);
    idle(); req(1, 3'd0, 2'd3, 1'b0, 5'd6); cyc();
    idle(); rsp(1, 64'hDEAD_BEEF_0123_4567); cyc();
    chk("t6_ld", od_b, 64'hDEAD_BEEF_0123_4567);
    idle(); req(0, 3'd0, 2'd3, 1'b0, 5'd1); req(1, 3'd4, 2'd3, 1'b0, 5'd1); #1;
    chk("t6_ld32_adel", o_adel[0], 1);
    chk("t6_ld64_adel", o_adel[1], 1);
    cyc();
    // random traffic
    for (int c = 0; c < 800; c++) begin
      for (int u = 0; u < 2; u++) begin
        rv[u] = 1'($urandom_range(0, 1));
        ra[u] = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
        rs[u] = 2'($urandom_range(0, 3));
        ru[u] = 1'($urandom_range(0, 1));
        rr[u] = 5'($urandom_range(0, 31));
        mrdy[u] = ($urandom_range(0, 3) != 0);
        rspv[u] = (mq[u].size() > 0 || mdisc[u] > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        rspd[u] = u ? {32'($urandom), 32'($urandom)} : {32'b0, 32'($urandom)};
        fl[u] = ($urandom_range(0, 15) == 0);
      end
      cyc();
    end
    for (int k = 0; k < 12; k++) begin
      idle();
      for (int u = 0; u < 2; u++) rspv[u] = (mq[u].size() > 0 || mdisc[u] > 0);
      cyc();
    end
    // spurious response is sticky
    idle(); rsp(1, 64'h0); cyc();
    chk("t6_spur", o_err[1], 1);
    idle(); cyc(); cyc();
    chk("t6_spur_hold", o_err[1], 1);
    // reset mid-operation; the late response is spurious
    idle(); req(0, 3'd0, 2'd2, 1'b0, 5'd2); cyc();
    do_reset();
    idle(); rsp(0, 64'h55); cyc();
    chk("t7_late_err", o_err[0], 1);
    chk("t7_late_nov", o_ov[0], 0);
    idle(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
